// File: rtl/sort3_share_arb.sv
// sort3_share_arb
//
// Round-robin arbiter and sequencer that shares one Sort3 datapath among
// NUM_REQ requesters. The granted triplet is driven to the sorter, its
// {valid,id} tag rides a SORT_LAT-deep shift register alongside the sorter
// pipeline, and the sorted result lands in a result FIFO. The FIFO returns
// results to a single consumer in issue order, tagged with the requester id.
//
// Issue is credit-limited. Every triplet in flight holds a FIFO slot before
// it arrives, so a stalled consumer can never cause a result to be dropped.
//
// Ports:
//   clock, reset         clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot or zero
//   req_data             requester i at [i*3*WIDTH +: 3*WIDTH], ordered {d3,d2,d1}
//   srt_data1/2/3        operands to the shared Sort3
//   srt_max/mid/min      Sort3 results, valid SORT_LAT cycles after presentation
//   res_valid/res_ready  result handshake toward the consumer
//   res_id               requester id of the head result
//   res_max/mid/min      sorted head result
//   busy                 any triplet in flight or any result buffered

module sort3_share_arb #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned SORT_LAT   = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned IdW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*3*WIDTH-1:0] req_data,

    output logic [WIDTH-1:0]           srt_data1,
    output logic [WIDTH-1:0]           srt_data2,
    output logic [WIDTH-1:0]           srt_data3,
    input  logic [WIDTH-1:0]           srt_max,
    input  logic [WIDTH-1:0]           srt_mid,
    input  logic [WIDTH-1:0]           srt_min,

    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [IdW-1:0]             res_id,
    output logic [WIDTH-1:0]           res_max,
    output logic [WIDTH-1:0]           res_mid,
    output logic [WIDTH-1:0]           res_min,

    output logic                       busy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    // Wide enough for inflight + fifo occupancy without overflow.
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + SORT_LAT + 1);

    typedef logic [IdW-1:0]       id_t;
    typedef logic [IdW:0]         id_ext_t;
    typedef logic [PtrW-1:0]      ptr_t;
    typedef logic [PtrW:0]        fcnt_t;
    typedef logic [CntW-1:0]      cnt_t;
    typedef logic [3*WIDTH-1:0]   trip_t;

    // (base + off) mod NUM_REQ, for base, off < NUM_REQ.
    function automatic id_t add_mod(input id_t base, input id_ext_t off);
        id_ext_t sum;
        sum = {1'b0, base} + off;
        if (sum >= id_ext_t'(NUM_REQ)) begin
            sum = sum - id_ext_t'(NUM_REQ);
        end
        return sum[IdW-1:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    id_t                ptr_q;
    trip_t              srt_q;

    logic [SORT_LAT-1:0] pipe_vld_q;
    id_t                 pipe_id_q [SORT_LAT];

    logic [WIDTH-1:0]   mem_max_q [FIFO_DEPTH];
    logic [WIDTH-1:0]   mem_mid_q [FIFO_DEPTH];
    logic [WIDTH-1:0]   mem_min_q [FIFO_DEPTH];
    id_t                mem_id_q  [FIFO_DEPTH];
    ptr_t               wr_ptr_q;
    ptr_t               rd_ptr_q;
    fcnt_t              fifo_cnt_q;

    // ------------------------------------------------------------------
    // Credit and arbitration
    // ------------------------------------------------------------------
    cnt_t               inflight_cnt;
    logic               credit;
    logic [NUM_REQ-1:0] rot_valid;
    logic               gnt_found;
    id_t                gnt_id;
    logic               accept;
    trip_t              gnt_trip;
    logic               push;
    logic               pop;

    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < SORT_LAT; i++) begin
            inflight_cnt = inflight_cnt + cnt_t'(pipe_vld_q[i]);
        end
    end

    // A pop only lowers fifo_cnt_q at the edge, so freed credit is seen next cycle.
    assign credit = (inflight_cnt + cnt_t'(fifo_cnt_q)) < cnt_t'(FIFO_DEPTH);

    // Rotate so that bit 0 is the requester at ptr_q, then take the first set bit.
    always_comb begin
        rot_valid = NUM_REQ'({req_valid, req_valid} >> ptr_q);
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && rot_valid[i]) begin
                gnt_found = 1'b1;
                gnt_id    = add_mod(ptr_q, id_ext_t'(i));
            end
        end
    end

    // Reset is folded in so no handshake can complete while held in reset.
    assign accept = reset & credit & gnt_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        gnt_trip = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == id_t'(i)) begin
                gnt_trip = req_data[i*3*WIDTH +: 3*WIDTH];
            end
        end
    end

    // Operands follow the granted triplet in the accept cycle, else hold.
    assign srt_data1 = accept ? gnt_trip[0*WIDTH +: WIDTH] : srt_q[0*WIDTH +: WIDTH];
    assign srt_data2 = accept ? gnt_trip[1*WIDTH +: WIDTH] : srt_q[1*WIDTH +: WIDTH];
    assign srt_data3 = accept ? gnt_trip[2*WIDTH +: WIDTH] : srt_q[2*WIDTH +: WIDTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            srt_q <= '0;
        end else if (accept) begin
            ptr_q <= add_mod(gnt_id, id_ext_t'(1));
            srt_q <= gnt_trip;
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracking: tag shift register matching the sorter latency
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipe_vld_q <= '0;
            for (int unsigned i = 0; i < SORT_LAT; i++) begin
                pipe_id_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= accept;
            pipe_id_q[0]  <= gnt_id;
            for (int unsigned i = 1; i < SORT_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
            end
        end
    end

    // The last stage lines up with valid sorter outputs.
    assign push = pipe_vld_q[SORT_LAT-1];
    assign pop  = res_valid & res_ready;

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_max_q[i] <= '0;
                mem_mid_q[i] <= '0;
                mem_min_q[i] <= '0;
                mem_id_q[i]  <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_max_q[wr_ptr_q] <= srt_max;
                mem_mid_q[wr_ptr_q] <= srt_mid;
                mem_min_q[wr_ptr_q] <= srt_min;
                mem_id_q[wr_ptr_q]  <= pipe_id_q[SORT_LAT-1];
                wr_ptr_q            <= wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + fcnt_t'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - fcnt_t'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Head entry straight from the storage flops; all zero out of reset.
    assign res_valid = (fifo_cnt_q != '0);
    assign res_id    = mem_id_q[rd_ptr_q];
    assign res_max   = mem_max_q[rd_ptr_q];
    assign res_mid   = mem_mid_q[rd_ptr_q];
    assign res_min   = mem_min_q[rd_ptr_q];

    assign busy = (inflight_cnt != '0) | (fifo_cnt_q != '0);

endmodule

// File: tb/tb_sort3_share_arb.sv
module tb_sort3_share_arb;

    logic        clock;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [71:0] req_data;
    logic [7:0]  srt_data1, srt_data2, srt_data3;
    logic [7:0]  srt_max, srt_mid, srt_min;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [7:0]  res_max, res_mid, res_min;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    sort3_share_arb #(
        .WIDTH      (8),
        .NUM_REQ    (3),
        .SORT_LAT   (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .srt_data1 (srt_data1),
        .srt_data2 (srt_data2),
        .srt_data3 (srt_data3),
        .srt_max   (srt_max),
        .srt_mid   (srt_mid),
        .srt_min   (srt_min),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_max   (res_max),
        .res_mid   (res_mid),
        .res_min   (res_min),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sort3 stand-in with one cycle of latency.
    function automatic logic [23:0] sort3(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
        logic [7:0] t;
        if (a < b) begin t = a; a = b; b = t; end
        if (b < c) begin t = b; b = c; c = t; end
        if (a < b) begin t = a; a = b; b = t; end
        return {a, b, c};
    endfunction

    always_ff @(posedge clock) begin
        {srt_max, srt_mid, srt_min} <= sort3(srt_data1, srt_data2, srt_data3);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Requester word {d3,d2,d1}.
    function automatic logic [23:0] tr(input logic [7:0] d1, input logic [7:0] d2,
                                       input logic [7:0] d3);
        return {d3, d2, d1};
    endfunction

    // Sorted word {max,mid,min}.
    function automatic logic [23:0] so(input logic [7:0] mx, input logic [7:0] md,
                                       input logic [7:0] mn);
        return {mx, md, mn};
    endfunction

    typedef struct {
        logic [2:0]  valid;
        logic [23:0] d0, d1, d2;
        logic [2:0]  e_ready;
        logic [23:0] e_srt;    // {srt_data3,srt_data2,srt_data1}, checked when e_ready != 0
        logic        e_rv;
        logic [1:0]  e_id;     // id/result checked when e_rv
        logic [23:0] e_res;
        logic        e_busy;
    } vec_t;

    function automatic vec_t v(input logic [2:0] valid, input logic [23:0] d0,
                               input logic [23:0] d1, input logic [23:0] d2,
                               input logic [2:0] er, input logic [23:0] es, input logic rv,
                               input logic [1:0] id, input logic [23:0] res, input logic bz);
        vec_t r;
        r.valid = valid; r.d0 = d0; r.d1 = d1; r.d2 = d2;
        r.e_ready = er; r.e_srt = es; r.e_rv = rv; r.e_id = id; r.e_res = res; r.e_busy = bz;
        return r;
    endfunction

    // Stall/drain sequence triplets: d1=8s+2, d2=8s+7, d3=8s+4.
    function automatic logic [23:0] mk3(input int s);
        return {8'(8*s+4), 8'(8*s+7), 8'(8*s+2)};
    endfunction

    function automatic logic [23:0] mk3_sorted(input int s);
        return {8'(8*s+7), 8'(8*s+4), 8'(8*s+2)};
    endfunction

    localparam int NV = 23;
    vec_t vecs [NV];

    int          cur_seq [3];
    int          seq;
    int          n_acc;
    int          n_acc2;
    int          n_pop;
    int          g;
    int          acc_ids [4];
    int          exp_ids [4];
    logic [25:0] exp_q [$];
    logic [25:0] e;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] z, ta, b1, b2, p0, p1, p2, q0, q1;
        z  = 24'h0;
        ta = tr(10, 5, 15);
        b1 = tr(50, 50, 50);
        b2 = tr(0, 255, 128);
        p0 = tr(20, 25, 30);
        p1 = tr(35, 30, 25);
        p2 = tr(45, 45, 40);
        q0 = tr(1, 2, 3);
        q1 = tr(4, 5, 6);

        // Single requester, latency and busy fall.
        vecs[0]  = v(3'b001, ta, z, z, 3'b001, ta, 0, 2'd0, z, 0);
        vecs[1]  = v(3'b000, z, z, z, 3'b000, z, 0, 2'd0, z, 1);
        vecs[2]  = v(3'b000, z, z, z, 3'b000, z, 1, 2'd0, so(15, 10, 5), 1);
        vecs[3]  = v(3'b000, z, z, z, 3'b000, z, 0, 2'd0, z, 0);
        // Ties and extremes; pointer sits at 1.
        vecs[4]  = v(3'b110, z, b1, b2, 3'b010, b1, 0, 2'd0, z, 0);
        vecs[5]  = v(3'b100, z, b1, b2, 3'b100, b2, 0, 2'd0, z, 1);
        vecs[6]  = v(3'b000, z, z, z, 3'b000, z, 1, 2'd1, so(50, 50, 50), 1);
        vecs[7]  = v(3'b000, z, z, z, 3'b000, z, 1, 2'd2, so(255, 128, 0), 1);
        vecs[8]  = v(3'b000, z, z, z, 3'b000, z, 0, 2'd0, z, 0);
        // Round robin over all three at full throughput.
        vecs[9]  = v(3'b111, p0, p1, p2, 3'b001, p0, 0, 2'd0, z, 0);
        vecs[10] = v(3'b111, p0, p1, p2, 3'b010, p1, 0, 2'd0, z, 1);
        vecs[11] = v(3'b111, p0, p1, p2, 3'b100, p2, 1, 2'd0, so(30, 25, 20), 1);
        vecs[12] = v(3'b111, p0, p1, p2, 3'b001, p0, 1, 2'd1, so(35, 30, 25), 1);
        vecs[13] = v(3'b111, p0, p1, p2, 3'b010, p1, 1, 2'd2, so(45, 45, 40), 1);
        vecs[14] = v(3'b111, p0, p1, p2, 3'b100, p2, 1, 2'd0, so(30, 25, 20), 1);
        vecs[15] = v(3'b000, z, z, z, 3'b000, z, 1, 2'd1, so(35, 30, 25), 1);
        vecs[16] = v(3'b000, z, z, z, 3'b000, z, 1, 2'd2, so(45, 45, 40), 1);
        vecs[17] = v(3'b000, z, z, z, 3'b000, z, 0, 2'd0, z, 0);
        // Req 2 was last: search wraps to req 0 before req 1.
        vecs[18] = v(3'b011, q0, q1, z, 3'b001, q0, 0, 2'd0, z, 0);
        vecs[19] = v(3'b010, q0, q1, z, 3'b010, q1, 0, 2'd0, z, 1);
        vecs[20] = v(3'b000, z, z, z, 3'b000, z, 1, 2'd0, so(3, 2, 1), 1);
        vecs[21] = v(3'b000, z, z, z, 3'b000, z, 1, 2'd1, so(6, 5, 4), 1);
        vecs[22] = v(3'b000, z, z, z, 3'b000, z, 0, 2'd0, z, 0);

        // Reset state, with requests pending to prove req_ready is held low.
        reset     = 1'b0;
        req_valid = 3'b111;
        req_data  = {p2, p1, p0};
        res_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("reset req_ready", req_ready, 3'b000);
        chk("reset res_valid", res_valid, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset res_data", {res_id, res_max, res_mid, res_min}, 26'h0);
        chk("reset srt_data", {srt_data3, srt_data2, srt_data1}, 24'h0);
        req_valid = 3'b000;
        #1;
        reset = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            req_valid = vecs[i].valid;
            req_data  = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
            res_ready = 1'b1;
            @(negedge clock);
            chk($sformatf("v%0d req_ready", i), req_ready, vecs[i].e_ready);
            chk($sformatf("v%0d res_valid", i), res_valid, vecs[i].e_rv);
            chk($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
            if (vecs[i].e_ready != 3'b000) begin
                chk($sformatf("v%0d srt_data", i), {srt_data3, srt_data2, srt_data1},
                    vecs[i].e_srt);
            end
            if (vecs[i].e_rv) begin
                chk($sformatf("v%0d res_id", i), res_id, vecs[i].e_id);
                chk($sformatf("v%0d res_data", i), {res_max, res_mid, res_min}, vecs[i].e_res);
            end
            step();
        end

        // Consumer stalled, everyone requesting: credit must stop issue at 4.
        seq = 1;
        for (int r = 0; r < 3; r++) begin
            cur_seq[r] = seq;
            seq++;
        end
        exp_ids[0] = 2; exp_ids[1] = 0; exp_ids[2] = 1; exp_ids[3] = 2;
        n_acc     = 0;
        res_ready = 1'b0;
        req_valid = 3'b111;
        for (int c = 0; c < 8; c++) begin
            req_data = {mk3(cur_seq[2]), mk3(cur_seq[1]), mk3(cur_seq[0])};
            @(negedge clock);
            chk($sformatf("stall c%0d onehot", c), {31'd0, $onehot0(req_ready)}, 1);
            g = -1;
            for (int j = 0; j < 3; j++) begin
                if (req_ready[j]) g = j;
            end
            if (g >= 0) begin
                chk($sformatf("stall c%0d srt_data", c), {srt_data3, srt_data2, srt_data1},
                    mk3(cur_seq[g]));
                if (n_acc < 4) acc_ids[n_acc] = g;
                exp_q.push_back({2'(g), mk3_sorted(cur_seq[g])});
                n_acc++;
            end
            step();
            if (g >= 0) begin
                cur_seq[g] = seq;
                seq++;
            end
        end
        chk("stall accept count", n_acc, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall grant %0d", k), acc_ids[k], exp_ids[k]);
        end
        @(negedge clock);
        chk("full req_ready", req_ready, 3'b000);
        chk("full res_valid", res_valid, 1'b1);
        chk("full res_id", res_id, 2'd2);
        chk("full busy", busy, 1'b1);
        step();

        // Release the consumer: drain in issue order while issue resumes.
        n_acc2    = 0;
        n_pop     = 0;
        res_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            req_valid = (c < 10) ? 3'b111 : 3'b000;
            req_data  = {mk3(cur_seq[2]), mk3(cur_seq[1]), mk3(cur_seq[0])};
            @(negedge clock);
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("drain c%0d unexpected result", c), res_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("drain c%0d res_id", c), res_id, e[25:24]);
                    chk($sformatf("drain c%0d res_data", c), {res_max, res_mid, res_min},
                        e[23:0]);
                end
                n_pop++;
            end
            g = -1;
            for (int j = 0; j < 3; j++) begin
                if (req_ready[j]) g = j;
            end
            if (g >= 0) begin
                exp_q.push_back({2'(g), mk3_sorted(cur_seq[g])});
                n_acc2++;
            end
            step();
            if (g >= 0) begin
                cur_seq[g] = seq;
                seq++;
            end
        end
        chk("resume accept count", n_acc2, 9);
        chk("drain pop count", n_pop, n_acc + n_acc2);
        chk("drain queue empty", exp_q.size(), 0);
        chk("drain busy", busy, 1'b0);

        // Asynchronous reset with work in flight and buffered.
        res_ready = 1'b0;
        req_valid = 3'b001;
        req_data  = {z, z, tr(11, 12, 13)};
        step();
        step();
        step();
        req_valid = 3'b000;
        #1;
        chk("pre-reset busy", busy, 1'b1);
        chk("pre-reset res_valid", res_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("async reset res_valid", res_valid, 1'b0);
        chk("async reset busy", busy, 1'b0);
        chk("async reset res_data", {res_id, res_max, res_mid, res_min}, 26'h0);
        chk("async reset srt_data", {srt_data3, srt_data2, srt_data1}, 24'h0);
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b1;
        step();
        req_valid = 3'b110;
        req_data  = {tr(1, 1, 1), tr(9, 8, 7), z};
        res_ready = 1'b1;
        @(negedge clock);
        chk("post-reset grant", req_ready, 3'b010);
        chk("post-reset srt_data", {srt_data3, srt_data2, srt_data1}, tr(9, 8, 7));
        step();
        req_valid = 3'b000;
        @(negedge clock);
        chk("post-reset no stale", res_valid, 1'b0);
        step();
        @(negedge clock);
        chk("post-reset res_valid", res_valid, 1'b1);
        chk("post-reset res_id", res_id, 2'd1);
        chk("post-reset res_data", {res_max, res_mid, res_min}, so(9, 8, 7));
        step();
        @(negedge clock);
        chk("post-reset empty", res_valid, 1'b0);
        chk("post-reset idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
